// File: rtl/mrv1_th_pkg.sv
// Shared thread-scheduler types and default sizes for the mrv1 issue stage.
package mrv1_th_pkg;

   localparam int MRV1_NUM_THREADS = 8;
   localparam int MRV1_ISSUE_WIDTH = 2;

   typedef logic [$clog2(MRV1_NUM_THREADS)-1:0] tid_t;
   typedef logic [MRV1_NUM_THREADS-1:0]         th_mask_t;

endpackage

// File: rtl/mrv1_th_pick_n.sv
// Combinational find-first-N picker: lane k grants the k-th lowest set bit of mask.
module mrv1_th_pick_n
   import mrv1_th_pkg::*;
#(
   parameter int N  = MRV1_NUM_THREADS,
   parameter int W  = MRV1_ISSUE_WIDTH,
   parameter int TW = $clog2(N)
) (
   input  logic [N-1:0]          mask,
   output logic [W-1:0][N-1:0]   gnt,
   output logic [W-1:0][TW-1:0]  tid,
   output logic [W-1:0]          vld
);

   logic [N-1:0] rem;

   always_comb begin
      rem = mask;
      gnt = '0;
      tid = '0;
      vld = '0;
      for (int k = 0; k < W; k++) begin
         // Two's-complement trick isolates the lowest remaining set bit.
         gnt[k] = rem & (~rem + N'(1));
         vld[k] = |rem;
         for (int i = 0; i < N; i++) begin
            if (gnt[k][i]) tid[k] = TW'(i);
         end
         rem = rem & ~gnt[k];
      end
   end

endmodule

// File: rtl/mrv1_th_issue_sched.sv
// Batch round-robin multi-issue thread scheduler with per-thread flush.
// Optional priority ordering is enabled by defining MRV1_TH_ISSUE_PRIO_EN.
module mrv1_th_issue_sched
   import mrv1_th_pkg::*;
#(
   parameter int NUM_THREADS_P = MRV1_NUM_THREADS,
   parameter int ISSUE_WIDTH_P = MRV1_ISSUE_WIDTH,
   parameter int ROUND_CNT_W_P = 16,
   localparam int tid_width_lp = $clog2(NUM_THREADS_P)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_THREADS_P-1:0]            issue_rdy_i,
   input  logic [NUM_THREADS_P-1:0]            th_flush_i,
`ifdef MRV1_TH_ISSUE_PRIO_EN
   input  logic [NUM_THREADS_P-1:0]            issue_prio_i,
`endif
   input  logic                                issue_ack_i,
   output logic [ISSUE_WIDTH_P-1:0]            issue_vld_o,
   output logic [ISSUE_WIDTH_P*tid_width_lp-1:0] issue_tid_o,
   output logic [ROUND_CNT_W_P-1:0]            batch_cnt_o,
   output logic [NUM_THREADS_P-1:0]            batch_pend_o
);

   logic [NUM_THREADS_P-1:0]                     batch_q, batch_nxt;
   logic [ROUND_CNT_W_P-1:0]                     batch_cnt_q;
   logic [NUM_THREADS_P-1:0]                     live, elig, cand, granted;
   logic [ISSUE_WIDTH_P-1:0][NUM_THREADS_P-1:0]  sel_gnt;
   logic [ISSUE_WIDTH_P-1:0][tid_width_lp-1:0]   sel_tid;
   logic [ISSUE_WIDTH_P-1:0]                     sel_vld;
   logic                                         cnt_inc;

   assign live = batch_q & issue_rdy_i & ~th_flush_i;
   assign elig = issue_rdy_i & ~th_flush_i;
   // An emptied batch is refilled in the same cycle so the issue slot never bubbles.
   assign cand = (|live) ? live : elig;

`ifdef MRV1_TH_ISSUE_PRIO_EN
   logic [ISSUE_WIDTH_P-1:0][NUM_THREADS_P-1:0]  hi_gnt, lo_gnt;
   logic [ISSUE_WIDTH_P-1:0][tid_width_lp-1:0]   hi_tid, lo_tid;
   logic [ISSUE_WIDTH_P-1:0]                     hi_vld, lo_vld;
   int                                           n_hi;

   mrv1_th_pick_n #(.N(NUM_THREADS_P), .W(ISSUE_WIDTH_P), .TW(tid_width_lp)) u_pick_hi (
      .mask (cand & issue_prio_i),
      .gnt  (hi_gnt),
      .tid  (hi_tid),
      .vld  (hi_vld)
   );

   mrv1_th_pick_n #(.N(NUM_THREADS_P), .W(ISSUE_WIDTH_P), .TW(tid_width_lp)) u_pick_lo (
      .mask (cand & ~issue_prio_i),
      .gnt  (lo_gnt),
      .tid  (lo_tid),
      .vld  (lo_vld)
   );

   // High-priority lanes fill from lane 0; remainder lanes pack directly after them.
   always_comb begin
      n_hi    = 0;
      sel_gnt = '0;
      sel_tid = '0;
      sel_vld = '0;
      for (int k = 0; k < ISSUE_WIDTH_P; k++) begin
         if (hi_vld[k]) n_hi = n_hi + 1;
      end
      for (int k = 0; k < ISSUE_WIDTH_P; k++) begin
         if (k < n_hi) begin
            sel_gnt[k] = hi_gnt[k];
            sel_tid[k] = hi_tid[k];
            sel_vld[k] = hi_vld[k];
         end else begin
            sel_gnt[k] = lo_gnt[k-n_hi];
            sel_tid[k] = lo_tid[k-n_hi];
            sel_vld[k] = lo_vld[k-n_hi];
         end
      end
   end
`else
   mrv1_th_pick_n #(.N(NUM_THREADS_P), .W(ISSUE_WIDTH_P), .TW(tid_width_lp)) u_pick (
      .mask (cand),
      .gnt  (sel_gnt),
      .tid  (sel_tid),
      .vld  (sel_vld)
   );
`endif

   always_comb begin
      granted = '0;
      for (int k = 0; k < ISSUE_WIDTH_P; k++) begin
         granted = granted | sel_gnt[k];
      end
   end

   // Unacknowledged grants stay in the batch and are re-presented next cycle.
   assign batch_nxt = issue_ack_i ? (cand & ~granted) : cand;
   assign cnt_inc   = issue_ack_i & (|sel_vld) & (batch_nxt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         batch_q     <= '0;
         batch_cnt_q <= '0;
      end else begin
         batch_q <= batch_nxt;
         if (cnt_inc) batch_cnt_q <= batch_cnt_q + ROUND_CNT_W_P'(1);
      end
   end

   assign issue_vld_o  = rst_i ? '0 : sel_vld;
   assign issue_tid_o  = rst_i ? '0 : sel_tid;
   assign batch_cnt_o  = batch_cnt_q;
   assign batch_pend_o = batch_q;

endmodule

// File: tb/tb_mrv1_th_issue_sched.sv
// Self-checking bench for mrv1_th_issue_sched (default build, 8 threads, 2 lanes).
module tb_mrv1_th_issue_sched;

   localparam int NT = 8;
   localparam int IW = 2;
   localparam int TW = 3;
   localparam int CW = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic [NT-1:0]       rdy, flush;
   logic                ack;
   logic [IW-1:0]       issue_vld;
   logic [IW*TW-1:0]    issue_tid;
   logic [CW-1:0]       batch_cnt;
   logic [NT-1:0]       batch_pend;

   int checks   = 0;
   int failures = 0;

   // Reference model: batch membership as a set of thread indices and a batch counter.
   bit [NT-1:0]    m_batch;
   bit [NT-1:0]    m_cand;
   logic [CW-1:0]  m_cnt;
   logic [TW-1:0]  exp_q[$];

   always #5 clk = ~clk;

   mrv1_th_issue_sched #(
      .NUM_THREADS_P (NT),
      .ISSUE_WIDTH_P (IW),
      .ROUND_CNT_W_P (CW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .issue_rdy_i  (rdy),
      .th_flush_i   (flush),
      .issue_ack_i  (ack),
      .issue_vld_o  (issue_vld),
      .issue_tid_o  (issue_tid),
      .batch_cnt_o  (batch_cnt),
      .batch_pend_o (batch_pend)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a, input int b);
      return (b << TW) | a;
   endfunction

   // Apply inputs, let logic settle, then compare against the model's view of this cycle.
   task automatic drive(input logic [NT-1:0] r, input logic [NT-1:0] f, input logic a);
      bit [NT-1:0]   elig, live;
      logic [31:0]   ev, et;
      int            k;
      rdy = r; flush = f; ack = a;
      #1;
      elig = r & ~f;
      live = m_batch & elig;
      m_cand = (live != 0) ? live : elig;
      exp_q.delete();
      for (int i = 0; i < NT; i++) begin
         if (m_cand[i] && exp_q.size() < IW) exp_q.push_back(TW'(i));
      end
      ev = 0; et = 0; k = 0;
      foreach (exp_q[j]) begin
         ev = ev | (32'd1 << k);
         et = et | (32'(exp_q[j]) << (k * TW));
         k++;
      end
      check("vld", 32'(issue_vld), ev);
      check("tid", 32'(issue_tid), et);
      check("pend", 32'(batch_pend), 32'(m_batch));
      check("cnt", 32'(batch_cnt), 32'(m_cnt));
   endtask

   task automatic tick();
      bit [NT-1:0] gr, nb;
      bit          any;
      gr = '0;
      any = exp_q.size() > 0;
      while (exp_q.size() > 0) gr[exp_q.pop_front()] = 1'b1;
      nb = ack ? (m_cand & ~gr) : m_cand;
      @(posedge clk);
      #2;
      if (ack && any && nb == 0) m_cnt = m_cnt + 1'b1;
      m_batch = nb;
   endtask

   initial begin
      rst = 1'b1; rdy = '1; flush = '0; ack = 1'b0;
      m_batch = '0; m_cnt = '0;
      #3;
      check("rst_vld", 32'(issue_vld), 0);
      check("rst_tid", 32'(issue_tid), 0);
      check("rst_cnt", 32'(batch_cnt), 0);
      check("rst_pend", 32'(batch_pend), 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Full ready mask, ack every cycle: four pairs then an immediate fresh batch.
      drive(8'hFF, 8'h00, 1'b1); check("tp1_c0", 32'(issue_tid), pk(0, 1)); tick();
      drive(8'hFF, 8'h00, 1'b1); check("tp1_c1", 32'(issue_tid), pk(2, 3)); tick();
      drive(8'hFF, 8'h00, 1'b1); check("tp1_c2", 32'(issue_tid), pk(4, 5)); tick();
      drive(8'hFF, 8'h00, 1'b1); check("tp1_c3", 32'(issue_tid), pk(6, 7)); tick();
      check("tp1_cnt", 32'(batch_cnt), 1);
      drive(8'hFF, 8'h00, 1'b1); check("tp1_c4", 32'(issue_tid), pk(0, 1));
      check("tp1_c4v", 32'(issue_vld), 2'b11); tick();
      drive(8'h00, 8'h00, 1'b1); tick();

      // Held grants without ack stay stable.
      for (int c = 0; c < 4; c++) begin
         drive(8'b0010_0110, 8'h00, (c == 3));
         check("tp2_hold", 32'(issue_tid), pk(1, 2));
         check("tp2_holdv", 32'(issue_vld), 2'b11);
         tick();
      end
      drive(8'b0010_0110, 8'h00, 1'b1);
      check("tp2_tail", 32'(issue_tid), pk(5, 0));
      check("tp2_tailv", 32'(issue_vld), 2'b01); tick();
      drive(8'h00, 8'h00, 1'b1); tick();

      // Thread 3 drops ready mid-batch and does not rejoin it.
      drive(8'hFF, 8'h00, 1'b1); tick();
      drive(8'hF7, 8'h00, 1'b1); check("tp3_drop", 32'(issue_tid), pk(2, 4)); tick();
      drive(8'hFF, 8'h00, 1'b1); check("tp3_next", 32'(issue_tid), pk(5, 6)); tick();
      drive(8'hFF, 8'h00, 1'b1); check("tp3_last", 32'(issue_tid), pk(7, 0)); tick();
      drive(8'h00, 8'h00, 1'b1); tick();

      // Flush of thread 2 removes it from the current batch.
      drive(8'hFF, 8'h00, 1'b1); tick();
      drive(8'hFF, 8'h04, 1'b1); check("tp4_flush", 32'(issue_tid), pk(3, 4)); tick();
      check("tp4_pend2", 32'(batch_pend[2]), 0);
      drive(8'h00, 8'h00, 1'b1); tick();

      // Async reset between edges discards the batch at once.
      drive(8'hFF, 8'h00, 1'b1); tick();
      drive(8'hFF, 8'h00, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("ar_vld", 32'(issue_vld), 0);
      check("ar_tid", 32'(issue_tid), 0);
      check("ar_cnt", 32'(batch_cnt), 0);
      check("ar_pend", 32'(batch_pend), 0);
      m_batch = '0; m_cnt = '0; exp_q.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      drive(8'h81, 8'h00, 1'b1); check("ar_grant", 32'(issue_tid), pk(0, 7)); tick();
      check("ar_cnt1", 32'(batch_cnt), 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [NT-1:0] r, f;
         r = NT'($urandom | $urandom);
         if ($urandom_range(0, 15) == 0) r = '0;
         f = ($urandom_range(0, 3) == 0) ? NT'(1 << $urandom_range(0, NT-1)) : '0;
         drive(r, f, ($urandom_range(0, 3) != 0));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
